// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM read arbiter.
//   req_id_t    : requester identifier (0 = instruction fetch, 1 = data/constant load)
//   rsp_meta_t  : bookkeeping captured at issue and presented with the response
package rom_arb_pkg;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_LOAD  = 1'b1;

    typedef struct packed {
        req_id_t id;
        logic    err;
    } rsp_meta_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with an issue enable.
// Ports:
//   clock, rst : clock and synchronous active-high reset
//   valid[1:0] : per-requester pending request
//   enable     : grants allowed this cycle
//   gnt[1:0]   : combinational one-hot (or zero) grant
// rr_last remembers the most recently granted requester; on a conflict the
// other one wins. Reset value 1 makes requester 0 win the first conflict.
module rr_arbiter2
    import rom_arb_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic rr_last_q;
    logic rr_last_d;

    // Last-granted register
    always_ff @(posedge clock) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

    // Grant selection; rr_last only moves when a grant is actually given
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (enable && !rst) begin
            case (valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt != 2'b00) begin
                rr_last_d = gnt[1];
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous-read ROM (1-cycle address->q latency) between an
// instruction-fetch requester (0) and a data/constant-load requester (1).
// Ports:
//   clock, rst              : clock, synchronous active-high reset
//   req{0,1}_valid/_addr    : request side, held until the matching gnt
//   req{0,1}_gnt            : combinational grant, at most one per cycle
//   rom_address / rom_q     : ROM address out, ROM data in (next cycle)
//   rsp_valid/_id/_data/_err: one response per grant, in grant order
//   rsp_ready               : consumer backpressure
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH        = 32,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned ROM_REGISTER_COUNT = 1024
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [ADDR_WIDTH-1:0]  req0_addr,
    output logic                   req0_gnt,
    input  logic                   req1_valid,
    input  logic [ADDR_WIDTH-1:0]  req1_addr,
    output logic                   req1_gnt,
    output logic [ADDR_WIDTH-1:0]  rom_address,
    input  logic [INSTR_WIDTH-1:0] rom_q,
    output logic                   rsp_valid,
    output logic                   rsp_id,
    output logic [INSTR_WIDTH-1:0] rsp_data,
    output logic                   rsp_err,
    input  logic                   rsp_ready
);

    localparam int unsigned CMP_W = 64;

    logic                  can_issue;
    logic                  issue;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    rsp_meta_t             sel_meta;

    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [ADDR_WIDTH-1:0] addr_hold_d;
    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    rsp_meta_t             meta_q;
    rsp_meta_t             meta_d;

    // A new read may start when the response slot is empty or draining now
    assign can_issue = !rsp_valid_q || rsp_ready;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (can_issue),
        .gnt    (gnt)
    );

    assign req0_gnt = gnt[0];
    assign req1_gnt = gnt[1];
    assign issue    = gnt[0] || gnt[1];

    // Granted request; range check is zero-extended, no address wrap
    always_comb begin
        sel_addr     = gnt[1] ? req1_addr : req0_addr;
        sel_meta.id  = gnt[1] ? REQ_LOAD : REQ_FETCH;
        sel_meta.err = CMP_W'(sel_addr) >= CMP_W'(ROM_REGISTER_COUNT);
    end

    // Replaying the held address keeps rom_q stable while a response stalls
    assign rom_address = issue ? sel_addr : addr_hold_q;

    // Next-state for the response slot
    always_comb begin
        addr_hold_d = addr_hold_q;
        meta_d      = meta_q;
        rsp_valid_d = rsp_valid_q;
        if (issue) begin
            addr_hold_d = sel_addr;
            meta_d      = sel_meta;
            rsp_valid_d = 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response slot registers; reset drops any in-flight response
    always_ff @(posedge clock) begin
        if (rst) begin
            addr_hold_q <= '0;
            meta_q      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            addr_hold_q <= addr_hold_d;
            meta_q      <= meta_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Response fields forced to zero when idle; data masked on range error
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_valid_q ? meta_q.id : 1'b0;
    assign rsp_err   = rsp_valid_q ? meta_q.err : 1'b0;
    assign rsp_data  = (rsp_valid_q && !meta_q.err) ? rom_q : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: directed scenarios plus a randomised run
// against a reference model and in-order scoreboard.
module tb_rom_read_arbiter;

    localparam int unsigned IW  = 32;
    localparam int unsigned AW  = 10;
    localparam int unsigned CNT = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic          req0_gnt, req1_gnt;
    logic [AW-1:0] rom_address;
    logic [IW-1:0] rom_q;
    logic          rsp_valid, rsp_id, rsp_err, rsp_ready;
    logic [IW-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_read_arbiter #(
        .INSTR_WIDTH        (IW),
        .ADDR_WIDTH         (AW),
        .ROM_REGISTER_COUNT (CNT)
    ) dut (
        .clock       (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_gnt    (req0_gnt),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_gnt    (req1_gnt),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_ready   (rsp_ready)
    );

    // ROM content: every word distinct and nonzero, all 1024 words populated
    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    always_ff @(posedge clk) rom_q <= rom_word(rom_address);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        drive_edge();
        drive_edge();
        rst = 1'b0;
    endtask

    // Random-phase model state
    typedef struct {
        logic          id;
        logic [AW-1:0] addr;
    } exp_t;
    exp_t exp_q[$];
    logic rr_m;
    logic vld_m;

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr  = '0;
        req1_addr  = '0;
        rsp_ready  = 1'b1;

        // Reset: no grants while rst is high, response slot empty
        drive_edge();
        drive_edge();
        @(negedge clk);
        check_eq("rst_gnt0", req0_gnt, 0);
        check_eq("rst_gnt1", req1_gnt, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        drive_edge();
        rst = 1'b0;

        // 1: single fetch request
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 10'h005;
        @(negedge clk);
        check_eq("t1_gnt0", req0_gnt, 1);
        check_eq("t1_gnt1", req1_gnt, 0);
        check_eq("t1_rom_addr", rom_address, 10'h005);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t1_rsp_valid", rsp_valid, 1);
        check_eq("t1_rsp_id", rsp_id, 0);
        check_eq("t1_rsp_err", rsp_err, 0);
        check_eq("t1_rsp_data", rsp_data, rom_word(10'h005));
        drive_edge();
        @(negedge clk);
        check_eq("t1_rsp_done", rsp_valid, 0);
        check_eq("t1_data_idle", rsp_data, 0);

        // 2: both requesters continuously valid alternate, starting with 0
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 10'h020;
        req1_valid = 1'b1;
        req1_addr  = 10'h0F0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t2_gnt0", req0_gnt, (k % 2) == 0);
            check_eq("t2_gnt1", req1_gnt, (k % 2) == 1);
            if (k > 0) begin
                check_eq("t2_rsp_valid", rsp_valid, 1);
                check_eq("t2_rsp_id", rsp_id, (k - 1) % 2);
                check_eq("t2_rsp_data", rsp_data,
                         ((k - 1) % 2) == 0 ? rom_word(10'h020) : rom_word(10'h0F0));
            end
            drive_edge();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check_eq("t2_last_id", rsp_id, 1);
        check_eq("t2_last_data", rsp_data, rom_word(10'h0F0));
        drive_edge();

        // 3: stalled response holds data and blocks grants
        req1_valid = 1'b1;
        req1_addr  = 10'h010;
        @(negedge clk);
        check_eq("t3_gnt1", req1_gnt, 1);
        drive_edge();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 10'h033;
        rsp_ready  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t3_stall_gnt0", req0_gnt, 0);
            check_eq("t3_stall_valid", rsp_valid, 1);
            check_eq("t3_stall_id", rsp_id, 1);
            check_eq("t3_stall_data", rsp_data, rom_word(10'h010));
            check_eq("t3_stall_addr", rom_address, 10'h010);
            drive_edge();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_rel_gnt0", req0_gnt, 1);
        check_eq("t3_rel_valid", rsp_valid, 1);
        check_eq("t3_rel_addr", rom_address, 10'h033);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t3_next_id", rsp_id, 0);
        check_eq("t3_next_data", rsp_data, rom_word(10'h033));
        drive_edge();

        // 4: range boundary at 512 words
        req0_valid = 1'b1;
        req0_addr  = 10'h200;
        @(negedge clk);
        check_eq("t4_gnt_oor", req0_gnt, 1);
        drive_edge();
        req0_addr = 10'h1FF;
        @(negedge clk);
        check_eq("t4_err", rsp_err, 1);
        check_eq("t4_err_data", rsp_data, 0);
        check_eq("t4_gnt_in", req0_gnt, 1);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_noerr", rsp_err, 0);
        check_eq("t4_data_1ff", rsp_data, rom_word(10'h1FF));
        drive_edge();

        // 5: reset while a response is stalled
        req1_valid = 1'b1;
        req1_addr  = 10'h044;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check_eq("t5_gnt1", req1_gnt, 1);
        drive_edge();
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 10'h055;
        @(negedge clk);
        check_eq("t5_valid_pre", rsp_valid, 1);
        check_eq("t5_rst_gnt0", req0_gnt, 0);
        check_eq("t5_rst_gnt1", req1_gnt, 0);
        drive_edge();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("t5_dropped", rsp_valid, 0);
        check_eq("t5_gnt0", req0_gnt, 1);
        check_eq("t5_gnt1", req1_gnt, 0);
        drive_edge();

        // 6: random traffic against model and scoreboard
        do_reset();
        rr_m  = 1'b1;
        vld_m = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic e0, e1, can, fire, g0, g1;
            exp_t e;
            if (cyc < 9980) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                rsp_ready  = 1'b1;
            end
            @(negedge clk);
            can = !vld_m || rsp_ready;
            e0 = 1'b0;
            e1 = 1'b0;
            if (can) begin
                if (req0_valid && req1_valid) begin
                    e0 = rr_m;
                    e1 = !rr_m;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            g0 = req0_gnt;
            g1 = req1_gnt;
            check_eq("r_gnt0", g0, e0);
            check_eq("r_gnt1", g1, e1);
            check_eq("r_rsp_valid", rsp_valid, vld_m);
            fire = vld_m && rsp_ready;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check_eq("r_sb_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("r_rsp_id", rsp_id, e.id);
                    check_eq("r_rsp_err", rsp_err, e.addr >= AW'(CNT));
                    check_eq("r_rsp_data", rsp_data,
                             e.addr >= AW'(CNT) ? '0 : rom_word(e.addr));
                end
            end
            if (e0 || e1) begin
                e.id   = e1;
                e.addr = e1 ? req1_addr : req0_addr;
                exp_q.push_back(e);
                rr_m  = e1;
                vld_m = 1'b1;
            end else if (fire) begin
                vld_m = 1'b0;
            end
            drive_edge();
            if (cyc < 9979) begin
                if (!req0_valid || g0) begin
                    req0_valid = ($urandom_range(0, 99) < 60);
                    req0_addr  = AW'($urandom);
                end
                if (!req1_valid || g1) begin
                    req1_valid = ($urandom_range(0, 99) < 60);
                    req1_addr  = AW'($urandom);
                end
            end
        end
        check_eq("r_sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
